fifo_umbrales: RTL and testbench

//  Synchronous single-clock FIFO, successor to the basic FIFO. Adds an occupancy count,

---
 rtl/fifo_umbrales.sv | 102 ++++++++++
 tb/tb_fifo_umbrales.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_umbrales.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through read port.
module fifo_umbrales #(
   parameter int BITNUMBER = 8,
   parameter int LENGTH    = 8,
   parameter int FWFT      = 0,
   localparam int CW       = $clog2(LENGTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Fifo_wr,
   input  logic                 Fifo_rd,
   input  logic [BITNUMBER-1:0] Fifo_Data_in,
   input  logic [CW-1:0]        Fifo_umbral_alto,
   input  logic [CW-1:0]        Fifo_umbral_bajo,
   output logic [BITNUMBER-1:0] Fifo_Data_out,
   output logic                 Fifo_valid,
   output logic                 Fifo_full,
   output logic                 Fifo_empty,
   output logic                 Fifo_almost_full,
   output logic                 Fifo_almost_empty,
   output logic [CW-1:0]        Fifo_count,
   output logic                 Fifo_overflow,
   output logic                 Fifo_underflow
);

   localparam int PW = $clog2(LENGTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LENGTH);

   logic [BITNUMBER-1:0] mem [LENGTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        count;
   logic                 rd_acc;
   logic                 wr_acc;

   assign Fifo_full         = (count == CNT_MAX);
   assign Fifo_empty        = (count == '0);
   assign Fifo_almost_full  = (count >= Fifo_umbral_alto);
   assign Fifo_almost_empty = (count <= Fifo_umbral_bajo);
   assign Fifo_count        = count;

   // A full FIFO may still take a write when the same cycle frees a slot.
   assign rd_acc = Fifo_rd && !Fifo_empty;
   assign wr_acc = Fifo_wr && (!Fifo_full || rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= Fifo_Data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         Fifo_overflow  <= 1'b0;
         Fifo_underflow <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         Fifo_overflow  <= Fifo_wr && !wr_acc;
         Fifo_underflow <= Fifo_rd && Fifo_empty;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign Fifo_Data_out = mem[rd_ptr];
         assign Fifo_valid    = !Fifo_empty;
      end else begin : g_reg
         logic [BITNUMBER-1:0] data_q;
         logic                 valid_q;

         // Read port samples the head before this edge's write, so a write into
         // the slot being freed is never seen by the read it races with.
         always_ff @(posedge clk) begin
            if (reset) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_acc;
               if (rd_acc)
                  data_q <= mem[rd_ptr];
            end
         end

         assign Fifo_Data_out = data_q;
         assign Fifo_valid    = valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed bench for fifo_umbrales: registered-read instance plus an FWFT instance.
module tb_fifo_umbrales;

   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       reset, wr, rd;
   logic [7:0] din;
   logic [7:0] dout;
   logic       valid, full, empty, afull, aempty, ovf, unf;
   logic [CW-1:0] count;

   logic       reset1, wr1, rd1;
   logic [7:0] din1;
   logic [7:0] dout1;
   logic       valid1, full1, empty1, afull1, aempty1, ovf1, unf1;
   logic [CW-1:0] count1;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fifo_umbrales #(.BITNUMBER(8), .LENGTH(8), .FWFT(0)) dut (
      .clk(clk), .reset(reset), .Fifo_wr(wr), .Fifo_rd(rd), .Fifo_Data_in(din),
      .Fifo_umbral_alto(4'd6), .Fifo_umbral_bajo(4'd2),
      .Fifo_Data_out(dout), .Fifo_valid(valid), .Fifo_full(full), .Fifo_empty(empty),
      .Fifo_almost_full(afull), .Fifo_almost_empty(aempty), .Fifo_count(count),
      .Fifo_overflow(ovf), .Fifo_underflow(unf)
   );

   fifo_umbrales #(.BITNUMBER(8), .LENGTH(8), .FWFT(1)) dut1 (
      .clk(clk), .reset(reset1), .Fifo_wr(wr1), .Fifo_rd(rd1), .Fifo_Data_in(din1),
      .Fifo_umbral_alto(4'd6), .Fifo_umbral_bajo(4'd2),
      .Fifo_Data_out(dout1), .Fifo_valid(valid1), .Fifo_full(full1), .Fifo_empty(empty1),
      .Fifo_almost_full(afull1), .Fifo_almost_empty(aempty1), .Fifo_count(count1),
      .Fifo_overflow(ovf1), .Fifo_underflow(unf1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc(input logic w, input logic r, input logic [7:0] d);
      wr = w; rd = r; din = d;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic cyc1(input logic w, input logic r, input logic [7:0] d);
      wr1 = w; rd1 = r; din1 = d;
      @(posedge clk); #1;
      wr1 = 1'b0; rd1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;
      reset1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;

      // 1: reset
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_aempty", aempty, 1);
      chk("rst_full", full, 0);
      chk("rst_dout", dout, 8'h00);
      chk("rst_valid", valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_unf", unf, 0);
      reset = 1'b0;
      reset1 = 1'b0;

      // 2: four writes, one read
      cyc(1, 0, 8'h0A);
      cyc(1, 0, 8'h0B);
      chk("t2_aempty_c2", aempty, 1);
      cyc(1, 0, 8'h0C);
      chk("t2_count3", count, 3);
      chk("t2_aempty_c3", aempty, 0);
      cyc(1, 0, 8'h0D);
      chk("t2_count4", count, 4);
      chk("t2_valid_nord", valid, 0);
      cyc(0, 1, 8'h00);
      chk("t2_dout", dout, 8'h0A);
      chk("t2_valid", valid, 1);
      chk("t2_count", count, 3);
      cyc(0, 0, 8'h00);
      chk("t2_valid_drop", valid, 0);
      chk("t2_dout_hold", dout, 8'h0A);
      cyc(0, 1, 8'h00); chk("t2_d1", dout, 8'h0B);
      cyc(0, 1, 8'h00); chk("t2_d2", dout, 8'h0C);
      cyc(0, 1, 8'h00); chk("t2_d3", dout, 8'h0D);
      chk("t2_empty", empty, 1);

      // 3: fill, overflow, drain
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0, 8'(i));
         if (i == 5) chk("t3_afull_c5", afull, 0);
         if (i == 6) chk("t3_afull_c6", afull, 1);
         if (i == 7) chk("t3_full_c7", full, 0);
      end
      chk("t3_full", full, 1);
      chk("t3_count8", count, 8);
      cyc(1, 0, 8'h09);
      chk("t3_ovf", ovf, 1);
      chk("t3_count_ovf", count, 8);
      cyc(0, 0, 8'h00);
      chk("t3_ovf_pulse", ovf, 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, 8'h00);
         chk($sformatf("t3_rd%0d", i), dout, i);
         chk($sformatf("t3_v%0d", i), valid, 1);
      end
      chk("t3_empty", empty, 1);

      // 4: underflow cases
      cyc(0, 1, 8'h00);
      chk("t4_unf", unf, 1);
      chk("t4_count", count, 0);
      chk("t4_dout_hold", dout, 8'h08);
      chk("t4_valid", valid, 0);
      cyc(1, 1, 8'h0F);
      chk("t4_wrrd_count", count, 1);
      chk("t4_wrrd_unf", unf, 1);
      chk("t4_wrrd_valid", valid, 0);
      cyc(0, 1, 8'h00);
      chk("t4_rd_0f", dout, 8'h0F);
      chk("t4_rd_valid", valid, 1);
      chk("t4_unf_clear", unf, 0);
      chk("t4_empty", empty, 1);

      // 5: simultaneous wr+rd at full, with pointer wrap
      for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
      chk("t5_full", full, 1);
      cyc(1, 1, 8'h0F);
      chk("t5_dout", dout, 8'h01);
      chk("t5_count", count, 8);
      chk("t5_no_ovf", ovf, 0);
      chk("t5_full_kept", full, 1);
      for (int i = 2; i <= 9; i++) begin
         cyc(0, 1, 8'h00);
         chk($sformatf("t5_rd%0d", i), dout, (i == 9) ? 8'h0F : i);
      end
      chk("t5_empty", empty, 1);

      // 6: FWFT instance
      chk("t6_rst_valid", valid1, 0);
      cyc1(1, 0, 8'h05);
      chk("t6_dout", dout1, 8'h05);
      chk("t6_valid", valid1, 1);
      cyc1(0, 0, 8'h00);
      chk("t6_dout_hold", dout1, 8'h05);
      chk("t6_valid_hold", valid1, 1);
      for (int i = 6; i <= 9; i++) cyc1(1, 0, 8'(i));
      chk("t6_count5", count1, 5);
      chk("t6_head", dout1, 8'h05);
      cyc1(0, 1, 8'h00);
      chk("t6_adv", dout1, 8'h06);
      chk("t6_count4", count1, 4);
      cyc1(1, 0, 8'h0A);
      chk("t6_count5b", count1, 5);
      reset1 = 1'b1;
      @(posedge clk); #1;
      reset1 = 1'b0;
      chk("t6_rst_count", count1, 0);
      chk("t6_rst_valid2", valid1, 0);
      chk("t6_rst_empty", empty1, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
